// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
//   DEPTH  - number of storage entries (power of two)
//   ADDR_W - index bits presented to the storage
//   PTR_W  - pointer width; the extra MSB is the wrap bit
//   gnt_e  - per-cycle grant encoding (at most one storage access per cycle)
package fifo_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int PTR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } gnt_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Client-side bundle of the FIFO controller.
//   master : client logic (drives push_req, pop_req, clear_err)
//   slave  : fifo_ctrl (drives acks, storage enables, pointers, flags, errors)
interface fifo_ctrl_if;
  import fifo_pkg::*;

  logic             push_req;
  logic             push_ack;
  logic             pop_req;
  logic             pop_ack;
  logic             rdata_valid;
  logic             mem_wr_en;
  logic             mem_rd_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             clear_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_req, pop_req, clear_err,
    input  push_ack, pop_ack, rdata_valid, mem_wr_en, mem_rd_en,
           wr_ptr, rd_ptr, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push_req, pop_req, clear_err,
    output push_ack, pop_ack, rdata_valid, mem_wr_en, mem_rd_en,
           wr_ptr, rd_ptr, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// PTR_W-bit wrap counter used for the FIFO write and read pointers.
//   clk    - clock
//   reset  - synchronous, active-high; clears the pointer
//   i_inc  - advance the pointer by one at this edge
//   o_ptr  - current pointer (low ADDR_W bits index storage, MSB is wrap bit)
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Natural PTR_W-bit rollover gives 01111->10000 and 11111->00000.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 16 x 8 single-port FIFO storage block.
// Grants at most one push or pop per cycle, drives the storage enables and
// pointers, and reports occupancy, full/empty and sticky error flags.
//   clk    - clock, all state on posedge
//   reset  - synchronous, active-high
//   bus    - fifo_ctrl_if.slave: requests/acks, storage enables, pointers,
//            count, full, empty, clear_err, overflow, underflow, rdata_valid
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  gnt_e             w_gnt;
  gnt_e             r_last_gnt;
  logic             r_rdata_valid;
  logic             r_overflow;
  logic             r_underflow;

  fifo_ptr u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_gnt == GNT_WR),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_gnt == GNT_RD),
    .o_ptr (w_rd_ptr)
  );

  // Full when the wrap bits differ but the storage indices coincide.
  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[PTR_W-1] != w_rd_ptr[PTR_W-1]) &&
                   (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]);

  // Single-access arbiter. When both sides request and neither flag decides,
  // alternate against the previous grant so neither side starves.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!reset) begin
      if (bus.push_req && bus.pop_req) begin
        if (w_empty) begin
          w_gnt = GNT_WR;
        end else if (w_full) begin
          w_gnt = GNT_RD;
        end else if (r_last_gnt == GNT_WR) begin
          w_gnt = GNT_RD;
        end else begin
          w_gnt = GNT_WR;
        end
      end else if (bus.push_req && !w_full) begin
        w_gnt = GNT_WR;
      end else if (bus.pop_req && !w_empty) begin
        w_gnt = GNT_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt    <= GNT_WR;
      r_rdata_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_gnt != GNT_NONE) begin
        r_last_gnt <= w_gnt;
      end
      // Storage data_out is valid the cycle after the read access.
      r_rdata_valid <= (w_gnt == GNT_RD);
      // A new error event beats a simultaneous clear.
      if (bus.push_req && w_full && (w_gnt != GNT_WR)) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_err) begin
        r_overflow <= 1'b0;
      end
      if (bus.pop_req && w_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.push_ack    = (w_gnt == GNT_WR);
  assign bus.pop_ack     = (w_gnt == GNT_RD);
  assign bus.mem_wr_en   = (w_gnt == GNT_WR);
  assign bus.mem_rd_en   = (w_gnt == GNT_RD);
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.wr_ptr      = w_wr_ptr;
  assign bus.rd_ptr      = w_rd_ptr;
  assign bus.count       = w_wr_ptr - w_rd_ptr;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl. The reference model tracks occupancy as
// an integer plus running totals of granted writes/reads, and derives every
// expected output from those each cycle.
module tb_fifo_ctrl;

  logic clk;
  logic reset;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rv     = 0;

  // Reference model state
  int         m_occ;
  logic [4:0] m_wr;
  logic [4:0] m_rd;
  bit         m_last_wr;
  bit         m_ovf;
  bit         m_udf;
  bit         m_rv;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ     = 0;
    m_wr      = '0;
    m_rd      = '0;
    m_last_wr = 1'b1;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    m_rv      = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check everything
  // visible before the next rising edge, then advance the model to that edge.
  task automatic step(input bit push, input bit pop, input bit clr, input bit rst);
    bit gw;
    bit gr;
    @(negedge clk);
    bus.push_req  = push;
    bus.pop_req   = pop;
    bus.clear_err = clr;
    reset         = rst;
    #1;
    gw = 1'b0;
    gr = 1'b0;
    if (!rst) begin
      if (push && pop) begin
        if (m_occ == 0)       gw = 1'b1;
        else if (m_occ == 16) gr = 1'b1;
        else if (m_last_wr)   gr = 1'b1;
        else                  gw = 1'b1;
      end else if (push) begin
        gw = (m_occ < 16);
      end else if (pop) begin
        gr = (m_occ > 0);
      end
    end
    chk("push_ack",    bus.push_ack, gw);
    chk("pop_ack",     bus.pop_ack, gr);
    chk("mem_wr_en",   bus.mem_wr_en, gw);
    chk("mem_rd_en",   bus.mem_rd_en, gr);
    chk("dual_en",     bus.mem_wr_en & bus.mem_rd_en, 1'b0);
    chk("count",       bus.count, 8'(m_occ));
    chk("full",        bus.full, m_occ == 16);
    chk("empty",       bus.empty, m_occ == 0);
    chk("wr_ptr",      bus.wr_ptr, m_wr);
    chk("rd_ptr",      bus.rd_ptr, m_rd);
    chk("overflow",    bus.overflow, m_ovf);
    chk("underflow",   bus.underflow, m_udf);
    chk("rdata_valid", bus.rdata_valid, m_rv);
    if (bus.rdata_valid === 1'b1) n_rv++;
    if (rst) begin
      model_reset();
    end else begin
      if (push && (m_occ == 16) && !gw) m_ovf = 1'b1;
      else if (clr)                     m_ovf = 1'b0;
      if (pop && (m_occ == 0))          m_udf = 1'b1;
      else if (clr)                     m_udf = 1'b0;
      m_occ = m_occ + int'(gw) - int'(gr);
      if (gw) begin m_wr = m_wr + 5'd1; m_last_wr = 1'b1; end
      if (gr) begin m_rd = m_rd + 5'd1; m_last_wr = 1'b0; end
      m_rv = gr;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.push_req  = 1'b0;
    bus.pop_req   = 1'b0;
    bus.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // 1: pop on empty -> no ack, underflow, then clear
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("t1_pop_ack", bus.pop_ack, 1'b0);
    chk("t1_empty", bus.empty, 1'b1);
    step(0, 0, 1, 0);
    chk("t1_underflow_set", bus.underflow, 1'b1);
    step(0, 0, 0, 0);
    chk("t1_underflow_clr", bus.underflow, 1'b0);

    // 2: fill, then push while full
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_full", bus.full, 1'b1);
    chk("t2_count", bus.count, 8'd16);
    chk("t2_wr_ptr", bus.wr_ptr, 8'h10);
    chk("t2_push_ack", bus.push_ack, 1'b0);
    step(0, 0, 0, 0);
    chk("t2_overflow", bus.overflow, 1'b1);

    // 3: drain, counting read-valid pulses
    n_rv = 0;
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t3_rd_ptr", bus.rd_ptr, 8'h10);
    chk("t3_empty", bus.empty, 1'b1);
    chk("t3_rv_pulses", 8'(n_rv), 8'd16);

    // 4: simultaneous requests at count=4 alternate
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t4_count", bus.count, 8'd4);

    // 5: push/pop pairs walk the pointers through the 11111->00000 wrap
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
    end

    // randomized traffic with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0));
    end

    // 6: reset mid-stream with a push pending
    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("t6_count_before", bus.count, 8'd7);
    chk("t6_no_wr_en", bus.mem_wr_en, 1'b0);
    step(0, 0, 0, 0);
    chk("t6_count_after", bus.count, 8'd0);
    chk("t6_empty_after", bus.empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
